// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   XLEN, INST_BYTES  : datapath width and instruction size in bytes
//   fetch_state_e     : fetch controller states (FETCH, FAULT)
//   fetch_entry_t     : one fetch-buffer entry {inst, pc, misalign}
package riscv_fetch_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            misalign;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer with a registered count and synchronous flush.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   flush             : empty the buffer this cycle (wins over push and pop)
//   push, push_data   : write an entry at the tail
//   pop               : drop the head entry
//   head              : head entry, all-zero while empty
//   count             : number of stored entries (0..DEPTH)
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] head_ptr_q, head_ptr_d;
  logic [PW-1:0] tail_ptr_q, tail_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d      = mem_q;
    head_ptr_d = head_ptr_q;
    tail_ptr_d = tail_ptr_q;
    count_d    = count_q;
    // Guards keep the storage consistent even if a caller misbehaves.
    do_push    = push && (count_q != CW'(DEPTH));
    do_pop     = pop && (count_q != '0);
    if (flush) begin
      head_ptr_d = '0;
      tail_ptr_d = '0;
      count_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[tail_ptr_q] = push_data;
        tail_ptr_d        = ptr_inc(tail_ptr_q);
      end
      if (do_pop) begin
        head_ptr_d = ptr_inc(head_ptr_q);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr_q <= '0;
      tail_ptr_q <= '0;
      count_q    <= '0;
    end else begin
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage carries no reset; the head output is masked while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = (count_q != '0) ? mem_q[head_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: drives a one-cycle synchronous instruction
// memory and queues returned words in a small buffer for the consumer.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   imem_pc / imem_inst         : memory address out, read data back one cycle later
//   redirect_valid, redirect_pc : branch/jump redirect; flushes everything
//   out_valid, out_ready        : consumer handshake on the buffer head
//   out_inst, out_pc            : head instruction and its address
//   out_misalign                : head is a misaligned-fetch fault marker
//   dbg_state                   : current controller state for observation
// Handshake: an entry transfers in every cycle where out_valid and out_ready are
// both 1; out_valid depends only on registered state, never on out_ready, and the
// head stays stable while out_valid=1 and out_ready=0.
module imem_fetch_ctrl
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  output logic [31:0]  imem_pc,
  input  logic [31:0]  imem_inst,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_inst,
  output logic [31:0]  out_pc,
  output logic         out_misalign,
  output fetch_state_e dbg_state
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   issued_pc_q, issued_pc_d;
  logic          inflight_q, inflight_d;

  logic          push;
  fetch_entry_t  push_data;
  logic          flush;
  logic          pop;
  fetch_entry_t  head;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          space;

  assign pop = out_valid && out_ready;

  // Occupancy one cycle ahead: the word in flight lands next cycle, so the
  // space test must leave room for it. pop implies count>=1, so no underflow.
  assign occupancy = {1'b0, count} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
  assign space     = occupancy < (CW + 1)'(DEPTH);

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    inflight_d  = 1'b0;
    push        = 1'b0;
    push_data   = '0;
    flush       = 1'b0;
    if (redirect_valid) begin
      // Returning data is dropped; the buffer empties.
      flush      = 1'b1;
      fetch_pc_d = redirect_pc;
      state_d    = FETCH;
    end else begin
      if (inflight_q) begin
        push      = 1'b1;
        push_data = '{inst: imem_inst, pc: issued_pc_q, misalign: 1'b0};
      end
      // A misaligned fetch_pc only follows a redirect, when nothing is in
      // flight, so the two push sources never collide.
      if (state_q == FETCH && space) begin
        if (fetch_pc_q[1:0] == 2'b00) begin
          inflight_d  = 1'b1;
          issued_pc_d = fetch_pc_q;
          fetch_pc_d  = fetch_pc_q + 32'(INST_BYTES);
        end else begin
          push      = 1'b1;
          push_data = '{inst: '0, pc: fetch_pc_q, misalign: 1'b1};
          state_d   = FAULT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      inflight_q  <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign imem_pc      = fetch_pc_q;
  assign out_valid    = (count != '0);
  assign out_inst     = head.inst;
  assign out_pc       = head.pc;
  assign out_misalign = head.misalign;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl. Memory model returns word[n]=n,
// i.e. the word at address a is a[19:2]. A second instance starts at
// 0xFFFF_FFF8 to cover PC wrap-around.
module tb_imem_fetch_ctrl;
  import riscv_fetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         rst2 = 1'b1;
  logic [31:0]  imem_pc, imem_inst;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = '0;
  logic         out_valid, out_ready = 1'b0;
  logic [31:0]  out_inst, out_pc;
  logic         out_misalign;
  fetch_state_e dbg_state;

  logic [31:0]  imem_pc2, imem_inst2;
  logic         out_valid2;
  logic [31:0]  out_inst2, out_pc2;
  logic         out_misalign2;
  fetch_state_e dbg_state2;

  imem_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .imem_pc        (imem_pc),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_misalign   (out_misalign),
    .dbg_state      (dbg_state)
  );

  imem_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk            (clk),
    .rst            (rst2),
    .imem_pc        (imem_pc2),
    .imem_inst      (imem_inst2),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .out_valid      (out_valid2),
    .out_ready      (1'b1),
    .out_inst       (out_inst2),
    .out_pc         (out_pc2),
    .out_misalign   (out_misalign2),
    .dbg_state      (dbg_state2)
  );

  // One-cycle synchronous memories, word[n] = n.
  always @(posedge clk) begin
    imem_inst  <= {14'b0, imem_pc[19:2]};
    imem_inst2 <= {14'b0, imem_pc2[19:2]};
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int pops    = 0;
  int wrap_seen = 0;
  logic [64:0] exp_q[$];   // {misalign, pc, inst}
  logic [64:0] exp2_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected delivery stream starting at pc; a misaligned start yields a
  // single fault marker and nothing after it.
  task automatic push_stream(input logic [31:0] start_pc);
    logic [31:0] p;
    exp_q.delete();
    p = start_pc;
    if (p[1:0] != 2'b00) begin
      exp_q.push_back({1'b1, p, 32'h0});
    end else begin
      for (int i = 0; i < 64; i++) begin
        exp_q.push_back({1'b0, p, {14'b0, p[19:2]}});
        p = p + 32'd4;
      end
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs just after the edge, then score any transfer.
  task automatic cycle(input logic r, input logic rdy, input logic redir, input logic [31:0] rpc);
    logic [64:0] e;
    @(posedge clk);
    #1;
    rst            = r;
    rst2           = rst2 & r;
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    if (out_valid && out_ready) begin
      pops++;
      check_eq("sb_avail", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("sb_pc", 64'(out_pc), 64'(e[63:32]));
        check_eq("sb_inst", 64'(out_inst), 64'(e[31:0]));
        check_eq("sb_misalign", 64'(out_misalign), 64'(e[64]));
      end
    end
    if (redir) push_stream(rpc);
    if (r) push_stream(32'h0);
    if (out_valid2 && exp2_q.size() != 0) begin
      e = exp2_q.pop_front();
      check_eq("wrap_pc", 64'(out_pc2), 64'(e[63:32]));
      check_eq("wrap_inst", 64'(out_inst2), 64'(e[31:0]));
      wrap_seen++;
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_pc"}, 64'(out_pc), 64'd0);
    check_eq({tag, "_inst"}, 64'(out_inst), 64'd0);
    check_eq({tag, "_misalign"}, 64'(out_misalign), 64'd0);
    check_eq({tag, "_imem_pc"}, 64'(imem_pc), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  int first_valid;

  initial begin
    begin
      logic [31:0] p;
      p = 32'hFFFF_FFF8;
      for (int i = 0; i < 256; i++) begin
        exp2_q.push_back({1'b0, p, {14'b0, p[19:2]}});
        p = p + 32'd4;
      end
    end

    // Reset, then stream with out_ready=1: first out_valid in cycle index 2.
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    first_valid = -1;
    pops = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      if (i == 0) check_idle("reset");
      if (out_valid && first_valid < 0) first_valid = i;
    end
    check_eq("first_valid_cycle", 64'(first_valid), 64'd2);
    check_eq("steady_pops", 64'(pops), 64'd30);

    // One-cycle reset mid-stream, then stall for 5 cycles.
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      if (i == 0) check_idle("midreset");
      if (i >= 2) begin
        check_eq("stall_valid", 64'(out_valid), 64'd1);
        check_eq("stall_head_pc", 64'(out_pc), 64'd0);
        check_eq("stall_head_inst", 64'(out_inst), 64'd0);
      end
    end
    check_eq("stall_imem_pc", 64'(imem_pc), 64'h8);

    // Release: every cycle delivers the next word in order.
    pops = 0;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("release_pops", 64'(pops), 64'd10);

    // Fill the buffer, then redirect to 0x100 while it is full.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("full_valid", 64'(out_valid), 64'd1);
    cycle(1'b0, 1'b0, 1'b1, 32'h100);
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      if (pops == 1 && out_valid && out_pc == 32'h100) check_eq("redir_first_pc", 64'(out_inst), 64'h40);
    end
    check_eq("redir_full_pops", 64'(pops), 64'd8);

    // Redirect mid-stream while a fetch is in flight; the same-cycle pop counts.
    pops = 0;
    cycle(1'b0, 1'b1, 1'b1, 32'h180);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("redir_stream_pops", 64'(pops), 64'd7);

    // Misaligned redirect: one fault marker, then silence until redirected.
    pops = 0;
    cycle(1'b0, 1'b1, 1'b1, 32'h102);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("fault_pops", 64'(pops), 64'd2);
    check_eq("fault_valid", 64'(out_valid), 64'd0);
    check_eq("fault_imem_pc", 64'(imem_pc), 64'h102);
    check_eq("fault_state", 64'(dbg_state), 64'(FAULT));

    pops = 0;
    cycle(1'b0, 1'b1, 1'b1, 32'h200);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check_eq("resume_pops", 64'(pops), 64'd6);
    check_eq("resume_state", 64'(dbg_state), 64'(FETCH));

    check_eq("wrap_seen", 64'(wrap_seen >= 3), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
